// File: rtl/phase_sequencer.sv
// Multi-cycle instruction sequencer: steps each instruction through fetch, decode,
// execute, memory and write-back, stalling on the memory ready handshake.
module phase_sequencer (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       start,
    input  logic       hlt_insn,
    input  logic       mem_access,
    input  logic [2:0] br_type,
    input  logic       zf,
    input  logic       sf,
    input  logic       cf,
    input  logic       of,
    input  logic       mem_ready,
    output logic [4:0] phase,
    output logic       mem_req,
    output logic       ct_taken,
    output logic       hlt,
    output logic       retire
);

    localparam logic [4:0] PH_NONE = 5'b00000;
    localparam logic [4:0] PH_F    = 5'b00001;
    localparam logic [4:0] PH_D    = 5'b00010;
    localparam logic [4:0] PH_E    = 5'b00100;
    localparam logic [4:0] PH_M    = 5'b01000;
    localparam logic [4:0] PH_W    = 5'b10000;

    typedef enum logic [2:0] {
        S_HALT,
        S_IREQ,
        S_F,
        S_D,
        S_E,
        S_M,
        S_W
    } state_t;

    state_t state_reg;
    state_t state_next;
    logic   ct_reg;
    logic   ct_next;
    logic   branch_cond;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg <= S_HALT;
            ct_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            ct_reg    <= ct_next;
        end
    end

    always_comb begin
        branch_cond = 1'b0;
        case (br_type)
            3'd0:    branch_cond = 1'b0;
            3'd1:    branch_cond = 1'b1;
            3'd2:    branch_cond = zf;
            3'd3:    branch_cond = !zf;
            3'd4:    branch_cond = sf;
            3'd5:    branch_cond = !sf;
            3'd6:    branch_cond = cf;
            default: branch_cond = of;
        endcase
    end

    // mem_ready only matters in the two states that hold a request open.
    always_comb begin
        state_next = state_reg;
        ct_next    = ct_reg;
        case (state_reg)
            S_HALT: if (start) state_next = S_IREQ;
            S_IREQ: if (mem_ready) state_next = S_F;
            S_F:    state_next = S_D;
            S_D:    state_next = hlt_insn ? S_HALT : S_E;
            S_E: begin
                ct_next    = branch_cond;
                state_next = mem_access ? S_M : S_W;
            end
            S_M:    if (mem_ready) state_next = S_W;
            S_W: begin
                ct_next    = 1'b0;
                state_next = S_IREQ;
            end
            default: begin
                ct_next    = 1'b0;
                state_next = S_HALT;
            end
        endcase
    end

    always_comb begin
        phase   = PH_NONE;
        mem_req = 1'b0;
        hlt     = 1'b0;
        retire  = 1'b0;
        case (state_reg)
            S_HALT:  hlt     = 1'b1;
            S_IREQ:  mem_req = 1'b1;
            S_F:     phase   = PH_F;
            S_D:     phase   = PH_D;
            S_E:     phase   = PH_E;
            S_M: begin
                phase   = PH_M;
                mem_req = 1'b1;
            end
            S_W: begin
                phase  = PH_W;
                retire = 1'b1;
            end
            default: hlt = 1'b1;
        endcase
    end

    assign ct_taken = ct_reg;

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: table of directed instructions, random instructions checked
// against a per-instruction phase-trace model, and a reset-during-memory-wait sequence.
module tb_phase_sequencer;

    localparam logic [4:0] PH_NONE = 5'b00000;
    localparam logic [4:0] PH_F    = 5'b00001;
    localparam logic [4:0] PH_D    = 5'b00010;
    localparam logic [4:0] PH_E    = 5'b00100;
    localparam logic [4:0] PH_M    = 5'b01000;
    localparam logic [4:0] PH_W    = 5'b10000;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       start, hlt_insn, mem_access, mem_ready;
    logic [2:0] br_type;
    logic       zf, sf, cf, of;
    logic [4:0] phase;
    logic       mem_req, ct_taken, hlt, retire;

    int   tests = 0;
    int   fails = 0;
    logic halted;

    always #5 clk = ~clk;

    phase_sequencer dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start),
        .hlt_insn   (hlt_insn),
        .mem_access (mem_access),
        .br_type    (br_type),
        .zf         (zf),
        .sf         (sf),
        .cf         (cf),
        .of         (of),
        .mem_ready  (mem_ready),
        .phase      (phase),
        .mem_req    (mem_req),
        .ct_taken   (ct_taken),
        .hlt        (hlt),
        .retire     (retire)
    );

    // One expected cycle: outputs to see, and inputs to apply in that cycle.
    typedef struct {
        logic [4:0] ph;
        logic mr, ct, h, r;
        logic rdy, hi, st, fl;
    } rec_t;

    typedef struct {
        int fw, mw;
        logic mem;
        logic [2:0] br;
        logic z, s, c, o, hi;
        logic exp_ct;
        int exp_cyc;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] outs();
        return {23'd0, phase, mem_req, ct_taken, hlt, retire};
    endfunction

    function automatic logic [31:0] pk(input logic [4:0] ph, input logic mr, ct, h, r);
        return {23'd0, ph, mr, ct, h, r};
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic rec_t mk(input logic [4:0] ph, input logic mr, ct, h, r,
                                input logic rdy, hi, st, fl);
        rec_t x;
        x.ph = ph; x.mr = mr; x.ct = ct; x.h = h; x.r = r;
        x.rdy = rdy; x.hi = hi; x.st = st; x.fl = fl;
        return x;
    endfunction

    function automatic logic model_taken(input logic [2:0] br, input logic z, s, c, o);
        logic [7:0] conds;
        conds = {o, c, ~s, s, ~z, z, 1'b1, 1'b0};
        return conds[br];
    endfunction

    // Builds the expected cycle trace of one instruction, then walks it cycle by cycle.
    task automatic run_insn(input int fw, input int mw, input logic mem, input logic [2:0] br,
                            input logic z, s, c, o, hi,
                            output int cycles, output logic w_ct);
        rec_t q[$];
        logic tk;
        tk = hi ? 1'b0 : model_taken(br, z, s, c, o);
        if (halted) q.push_back(mk(PH_NONE, 0, 0, 1, 0, rnd(), rnd(), 1, 0));
        for (int i = 0; i <= fw; i++) q.push_back(mk(PH_NONE, 1, 0, 0, 0, i == fw, rnd(), rnd(), 0));
        q.push_back(mk(PH_F, 0, 0, 0, 0, rnd(), rnd(), rnd(), 0));
        q.push_back(mk(PH_D, 0, 0, 0, 0, rnd(), hi, rnd(), 0));
        if (!hi) begin
            q.push_back(mk(PH_E, 0, 0, 0, 0, rnd(), rnd(), rnd(), 1));
            if (mem)
                for (int i = 0; i <= mw; i++) q.push_back(mk(PH_M, 1, tk, 0, 0, i == mw, rnd(), rnd(), 0));
            q.push_back(mk(PH_W, 0, tk, 0, 1, rnd(), rnd(), rnd(), 0));
        end
        mem_access = mem;
        br_type    = br;
        cycles     = 0;
        w_ct       = 1'b0;
        foreach (q[k]) begin
            @(negedge clk);
            check("cycle", outs(), pk(q[k].ph, q[k].mr, q[k].ct, q[k].h, q[k].r));
            if (!q[k].h) cycles++;
            if (q[k].ph == PH_W) w_ct = ct_taken;
            mem_ready = q[k].rdy;
            hlt_insn  = q[k].hi;
            start     = q[k].st;
            if (q[k].fl) begin
                zf = z; sf = s; cf = c; of = o;
            end else begin
                zf = rnd(); sf = rnd(); cf = rnd(); of = rnd();
            end
        end
        halted = hi;
    endtask

    vec_t vt[14];
    int   cyc;
    logic wct;

    initial begin
        vt[0]  = '{0, 0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5};
        vt[1]  = '{0, 0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5};
        vt[2]  = '{3, 0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8};
        vt[3]  = '{0, 2, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8};
        vt[4]  = '{0, 0, 1'b1, 3'd2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6};
        vt[5]  = '{0, 0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5};
        vt[6]  = '{0, 0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5};
        vt[7]  = '{1, 0, 1'b0, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6};
        vt[8]  = '{0, 0, 1'b0, 3'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5};
        vt[9]  = '{0, 0, 1'b0, 3'd6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5};
        vt[10] = '{0, 0, 1'b0, 3'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5};
        vt[11] = '{0, 1, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 7};
        vt[12] = '{0, 0, 1'b0, 3'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3};
        vt[13] = '{0, 0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5};

        n_rst = 1'b0; start = 1'b0; hlt_insn = 1'b0; mem_access = 1'b0; mem_ready = 1'b0;
        br_type = 3'd0; zf = 1'b0; sf = 1'b0; cf = 1'b0; of = 1'b0;
        #1 check("reset_state", outs(), pk(PH_NONE, 0, 0, 1, 0));
        repeat (2) @(negedge clk);
        n_rst  = 1'b1;
        halted = 1'b1;

        repeat (10) begin
            @(negedge clk);
            check("idle", outs(), pk(PH_NONE, 0, 0, 1, 0));
            start     = 1'b0;
            mem_ready = rnd();
        end

        for (int i = 0; i < 14; i++) begin
            run_insn(vt[i].fw, vt[i].mw, vt[i].mem, vt[i].br, vt[i].z, vt[i].s, vt[i].c,
                     vt[i].o, vt[i].hi, cyc, wct);
            check($sformatf("vec%0d_cycles", i), 32'(cyc), 32'(vt[i].exp_cyc));
            check($sformatf("vec%0d_taken", i), {31'd0, wct}, {31'd0, vt[i].exp_ct});
            $display("[TB] vec %0d br=%0d mem=%0b hlt=%0b cycles=%0d taken=%0b",
                     i, vt[i].br, vt[i].mem, vt[i].hi, cyc, wct);
        end

        for (int i = 0; i < 40; i++) begin
            logic hi_r;
            hi_r = ($urandom_range(0, 7) == 0);
            run_insn(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rnd(),
                     3'($urandom_range(0, 7)), rnd(), rnd(), rnd(), rnd(), hi_r, cyc, wct);
            $display("[TB] rand %0d hlt=%0b cycles=%0d taken=%0b", i, hi_r, cyc, wct);
        end
        if (halted) run_insn(0, 0, 1'b0, 3'd0, 0, 0, 0, 0, 1'b0, cyc, wct);

        // Abort while a data request is outstanding; outputs must collapse before any edge.
        mem_access = 1'b1; br_type = 3'd1; hlt_insn = 1'b0;
        @(negedge clk); check("abort_ireq", outs(), pk(PH_NONE, 1, 0, 0, 0));
        mem_ready = 1'b1; start = 1'b0;
        @(negedge clk); check("abort_f", outs(), pk(PH_F, 0, 0, 0, 0));
        @(negedge clk); check("abort_d", outs(), pk(PH_D, 0, 0, 0, 0));
        @(negedge clk); check("abort_e", outs(), pk(PH_E, 0, 0, 0, 0));
        @(negedge clk); check("abort_m", outs(), pk(PH_M, 1, 1, 0, 0));
        mem_ready = 1'b0;
        #2 n_rst = 1'b0;
        #1 check("reset_mid_m", outs(), pk(PH_NONE, 0, 0, 1, 0));
        @(negedge clk); check("reset_held", outs(), pk(PH_NONE, 0, 0, 1, 0));
        n_rst  = 1'b1;
        halted = 1'b1;
        $display("[TB] reset mid-M done");

        run_insn(1, 1, 1'b1, 3'd2, 1'b1, 0, 0, 0, 1'b0, cyc, wct);
        check("recover_cycles", 32'(cyc), 32'd8);
        check("recover_taken", {31'd0, wct}, 32'd1);
        $display("[TB] recovery cycles=%0d taken=%0b", cyc, wct);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
